mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client burst arbiter between the L1 caches and the single-word external memory port. It accepts 4-word line transactions from the D-cache and I-cache memory interfaces and serialises each into four single-word SRAM accesses. On the cache side it returns the cache's burst handshake: `MEM_Valid`, `MEM_Data_Read` and `MEM_Last`. It sits directly downstream of the D-cache memory-transaction port, and round-robin arbitration keeps writeout-then-populate sequences and I-fetch misses fair.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDRESS_WIDTH`, 21, word-address width; the low 2 bits are the word-in-line offset.
- `i_Clk`  in  1  clock; all logic on rising edge.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_DC_MEM_Valid`, `i_IC_MEM_Valid`  in  1  client request, held for the whole burst.
- `i_DC_MEM_Read_Write_n`, `i_IC_MEM_Read_Write_n`  in  1  1 = line read, 0 = line write.
- `i_DC_MEM_Address`, `i_IC_MEM_Address`  in  ADDRESS_WIDTH  line base, low 2 bits 0.
- `i_DC_MEM_Data`, `i_IC_MEM_Data`  in  DATA_WIDTH  current write word; the client advances it after each `Data_Read`.
- `o_DC_MEM_Valid`, `o_IC_MEM_Valid`  out  1  read-beat strobe; data is valid in the same cycle.
- `o_DC_MEM_Data_Read`, `o_IC_MEM_Data_Read`  out  1  write-beat consumed strobe.
- `o_DC_MEM_Last`, `o_IC_MEM_Last`  out  1  asserted together with the 4th beat strobe.
- `o_DC_MEM_Data`, `o_IC_MEM_Data`  out  DATA_WIDTH  read data; driven to both clients.
- `o_SRAM_Req`  out  1  word access request, held until ack.
- `o_SRAM_We`  out  1  1 = write.
- `o_SRAM_Address`  out  ADDRESS_WIDTH  word address.
- `o_SRAM_Write_Data`  out  DATA_WIDTH  write word.
- `i_SRAM_Ack`  in  1  access complete; read data valid in the same cycle.
- `i_SRAM_Read_Data`  in  DATA_WIDTH  read word.

## Operation
- Every output is a register. On reset all outputs are 0, the state is IDLE, `Beat`=0, and the round-robin pointer `Last_Grant`=IC, so DC wins the first tie.
- States:
  - IDLE: if any `i_*_MEM_Valid` is high, register `Grant` (round-robin: on a tie the client not in `Last_Grant` wins), then go to SETUP.
  - SETUP: one cycle, lets the client's registered command settle. At the end of it latch rw, base address and write data from the granted client, set `Beat`=0, raise `o_SRAM_Req` with `o_SRAM_Address`={base[high],Beat}, and go to ACCESS.
  - ACCESS: hold `o_SRAM_Req` and all SRAM fields until `i_SRAM_Ack`. On the ack edge:
    - drop `Req`;
    - read: register `i_SRAM_Read_Data` into the client data output and pulse the granted client's `MEM_Valid`;
    - write: pulse the granted client's `Data_Read`;
    - if `Beat`==3, also pulse `Last`, set `Last_Grant`=`Grant`, and go to DONE;
    - otherwise `Beat`+1; a read goes to ACCESS with `Req` re-raised one cycle later (via RGAP), a write goes to WSETTLE.
  - RGAP: one cycle with `Req` low, then `Req` high in ACCESS.
  - WSETTLE: two cycles. The client updates its data word after seeing `Data_Read`. At the end, latch the client's `MEM_Data` into `o_SRAM_Write_Data`, raise `Req`, and go to ACCESS.
  - DONE: one cycle. The client's `MEM_Valid` is ignored here because the client deasserts it one cycle after `Last`. Then go to IDLE.
- A client holding `Valid` high across `Last` (writeout followed by populate) is treated as a new request and re-arbitrated in IDLE.
- The beat counter is 2 bits and wraps 3→0 only via DONE. The address low bits equal `Beat`; the input address low bits are ignored.
- A client dropping `Valid` mid-burst is a protocol violation; the burst still completes all 4 beats.
- The non-granted client's strobes stay 0 at all times.

## Timing
- Client `Valid` seen in cycle T → `Grant` at T+1 → first `o_SRAM_Req` at T+2.
- Read beat: ack sampled at edge E → client `MEM_Valid` and data in cycle E+1 → next `Req` in cycle E+2.
- Write beat: ack at edge E → `Data_Read` in E+1 → next `Req` in E+3, carrying the client's updated word.
- With 1-cycle SRAM ack, a 4-beat read is T+2..T+9 and `Last` is in T+9. Next arbitration is possible no earlier than 2 cycles after `Last`.
- Async reset mid-burst clears `Req` and all strobes immediately. The partially written line in SRAM is not restored.

## Test plan
- DC read at 0x00120, SRAM returns 0xA0..0xA3 with zero-wait ack: DC `Valid` pulses 4 times with data A0,A1,A2,A3; `Last` only with A3; `o_SRAM_Address` sequence 0x120..0x123.
- DC write at 0x00040, client words 0x11,0x22,0x33,0x44 advanced on `Data_Read`: SRAM sees We=1 with addresses 0x40..0x43 and data 0x11..0x44 in order; `Last` with the 4th `Data_Read`.
- DC writeout (base 0x40) with `Valid` held high into a populate (base 0x80): two complete bursts; the second starts no earlier than 2 cycles after the first `Last`, with no beat interleaving.
- DC and IC request in the same cycle, twice in a row: first grant DC, second IC, third DC; IC strobes stay 0 during DC bursts.
- SRAM ack delayed 3 cycles per beat: `Req` and address/data are held stable until ack; exactly one strobe per beat.
- `i_Reset_n` pulled low during beat 2 of a read: all outputs 0 immediately; after release, an IC request at 0x300 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client round-robin arbiter splitting 4-word line bursts into single-word SRAM accesses
module mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 21
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_DC_MEM_Valid,
    input  logic                     i_DC_MEM_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_DC_MEM_Address,
    input  logic [DATA_WIDTH-1:0]    i_DC_MEM_Data,
    input  logic                     i_IC_MEM_Valid,
    input  logic                     i_IC_MEM_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_IC_MEM_Address,
    input  logic [DATA_WIDTH-1:0]    i_IC_MEM_Data,
    output logic                     o_DC_MEM_Valid,
    output logic                     o_DC_MEM_Data_Read,
    output logic                     o_DC_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_DC_MEM_Data,
    output logic                     o_IC_MEM_Valid,
    output logic                     o_IC_MEM_Data_Read,
    output logic                     o_IC_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_IC_MEM_Data,
    output logic                     o_SRAM_Req,
    output logic                     o_SRAM_We,
    output logic [ADDRESS_WIDTH-1:0] o_SRAM_Address,
    output logic [DATA_WIDTH-1:0]    o_SRAM_Write_Data,
    input  logic                     i_SRAM_Ack,
    input  logic [DATA_WIDTH-1:0]    i_SRAM_Read_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RGAP,
        S_WSETTLE,
        S_DONE
    } state_t;

    state_t                   state;
    logic                     grant_ic;
    logic                     last_grant_ic;
    logic                     line_read;
    logic                     settle_cnt;
    logic [1:0]               beat;
    logic [ADDRESS_WIDTH-3:0] line_base;
    logic [DATA_WIDTH-1:0]    read_data;

    logic                     sel_read_write_n;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [1:0]               unused_offset;

    assign sel_read_write_n = grant_ic ? i_IC_MEM_Read_Write_n : i_DC_MEM_Read_Write_n;
    assign sel_address      = grant_ic ? i_IC_MEM_Address      : i_DC_MEM_Address;
    assign sel_data         = grant_ic ? i_IC_MEM_Data         : i_DC_MEM_Data;
    // The word offset always comes from the beat counter, never from the client.
    assign unused_offset    = sel_address[1:0];

    assign o_DC_MEM_Data = read_data;
    assign o_IC_MEM_Data = read_data;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state              <= S_IDLE;
            grant_ic           <= 1'b0;
            last_grant_ic      <= 1'b1;
            line_read          <= 1'b0;
            settle_cnt         <= 1'b0;
            beat               <= 2'd0;
            line_base          <= '0;
            read_data          <= '0;
            o_DC_MEM_Valid     <= 1'b0;
            o_DC_MEM_Data_Read <= 1'b0;
            o_DC_MEM_Last      <= 1'b0;
            o_IC_MEM_Valid     <= 1'b0;
            o_IC_MEM_Data_Read <= 1'b0;
            o_IC_MEM_Last      <= 1'b0;
            o_SRAM_Req         <= 1'b0;
            o_SRAM_We          <= 1'b0;
            o_SRAM_Address     <= '0;
            o_SRAM_Write_Data  <= '0;
        end else begin
            o_DC_MEM_Valid     <= 1'b0;
            o_DC_MEM_Data_Read <= 1'b0;
            o_DC_MEM_Last      <= 1'b0;
            o_IC_MEM_Valid     <= 1'b0;
            o_IC_MEM_Data_Read <= 1'b0;
            o_IC_MEM_Last      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_DC_MEM_Valid || i_IC_MEM_Valid) begin
                        if (i_DC_MEM_Valid && i_IC_MEM_Valid) begin
                            grant_ic <= ~last_grant_ic;
                        end else begin
                            grant_ic <= i_IC_MEM_Valid;
                        end
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    line_read         <= sel_read_write_n;
                    line_base         <= sel_address[ADDRESS_WIDTH-1:2];
                    o_SRAM_We         <= ~sel_read_write_n;
                    o_SRAM_Write_Data <= sel_data;
                    o_SRAM_Address    <= {sel_address[ADDRESS_WIDTH-1:2], 2'b00};
                    o_SRAM_Req        <= 1'b1;
                    beat              <= 2'd0;
                    state             <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (i_SRAM_Ack) begin
                        o_SRAM_Req <= 1'b0;
                        if (line_read) begin
                            read_data      <= i_SRAM_Read_Data;
                            o_DC_MEM_Valid <= ~grant_ic;
                            o_IC_MEM_Valid <= grant_ic;
                        end else begin
                            o_DC_MEM_Data_Read <= ~grant_ic;
                            o_IC_MEM_Data_Read <= grant_ic;
                        end
                        if (beat == 2'd3) begin
                            o_DC_MEM_Last <= ~grant_ic;
                            o_IC_MEM_Last <= grant_ic;
                            last_grant_ic <= grant_ic;
                            state         <= S_DONE;
                        end else begin
                            beat       <= beat + 2'd1;
                            settle_cnt <= 1'b0;
                            state      <= line_read ? S_RGAP : S_WSETTLE;
                        end
                    end
                end

                S_RGAP: begin
                    o_SRAM_Address <= {line_base, beat};
                    o_SRAM_Req     <= 1'b1;
                    state          <= S_ACCESS;
                end

                // Second cycle samples the word the client advanced after Data_Read.
                S_WSETTLE: begin
                    if (settle_cnt) begin
                        o_SRAM_Write_Data <= sel_data;
                        o_SRAM_Address    <= {line_base, beat};
                        o_SRAM_Req        <= 1'b1;
                        state             <= S_ACCESS;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end

                S_DONE: begin
                    beat  <= 2'd0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table and directed sequences for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        i_Reset_n;
    logic        i_DC_MEM_Valid, i_DC_MEM_Read_Write_n;
    logic [20:0] i_DC_MEM_Address;
    logic [31:0] i_DC_MEM_Data;
    logic        i_IC_MEM_Valid, i_IC_MEM_Read_Write_n;
    logic [20:0] i_IC_MEM_Address;
    logic [31:0] i_IC_MEM_Data;
    logic        o_DC_MEM_Valid, o_DC_MEM_Data_Read, o_DC_MEM_Last;
    logic [31:0] o_DC_MEM_Data;
    logic        o_IC_MEM_Valid, o_IC_MEM_Data_Read, o_IC_MEM_Last;
    logic [31:0] o_IC_MEM_Data;
    logic        o_SRAM_Req, o_SRAM_We;
    logic [20:0] o_SRAM_Address;
    logic [31:0] o_SRAM_Write_Data;
    logic        i_SRAM_Ack;
    logic [31:0] i_SRAM_Read_Data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_Clk                 (clk),
        .i_Reset_n             (i_Reset_n),
        .i_DC_MEM_Valid        (i_DC_MEM_Valid),
        .i_DC_MEM_Read_Write_n (i_DC_MEM_Read_Write_n),
        .i_DC_MEM_Address      (i_DC_MEM_Address),
        .i_DC_MEM_Data         (i_DC_MEM_Data),
        .i_IC_MEM_Valid        (i_IC_MEM_Valid),
        .i_IC_MEM_Read_Write_n (i_IC_MEM_Read_Write_n),
        .i_IC_MEM_Address      (i_IC_MEM_Address),
        .i_IC_MEM_Data         (i_IC_MEM_Data),
        .o_DC_MEM_Valid        (o_DC_MEM_Valid),
        .o_DC_MEM_Data_Read    (o_DC_MEM_Data_Read),
        .o_DC_MEM_Last         (o_DC_MEM_Last),
        .o_DC_MEM_Data         (o_DC_MEM_Data),
        .o_IC_MEM_Valid        (o_IC_MEM_Valid),
        .o_IC_MEM_Data_Read    (o_IC_MEM_Data_Read),
        .o_IC_MEM_Last         (o_IC_MEM_Last),
        .o_IC_MEM_Data         (o_IC_MEM_Data),
        .o_SRAM_Req            (o_SRAM_Req),
        .o_SRAM_We             (o_SRAM_We),
        .o_SRAM_Address        (o_SRAM_Address),
        .o_SRAM_Write_Data     (o_SRAM_Write_Data),
        .i_SRAM_Ack            (i_SRAM_Ack),
        .i_SRAM_Read_Data      (i_SRAM_Read_Data)
    );

    typedef struct {
        bit             ic;
        bit             rd;
        logic [20:0]    addr;
        logic [20:0]    exp_base;
        logic [3:0][31:0] w;
        int             ack_wait;
        bit             timing;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor-owned state: SRAM model, client write-word sequencing, event logs.
    int cyc = 0;
    int last_cnt = 0, dc_dr_cnt = 0, ic_dr_cnt = 0;
    int stab_bad = 0, stab_n = 0, overlap = 0, orphan = 0;
    logic [20:0] s_addr[$];
    logic        s_we[$];
    logic [31:0] s_wd[$];
    int          s_cyc[$];
    logic        b_ic[$], b_kind[$], b_last[$];
    logic [31:0] b_data[$];
    int          b_cyc[$];

    // Main-owned configuration read by the monitor.
    logic [3:0][31:0] cur_words, dc_words, ic_words;
    int ack_wait = 0, dc_start = 0, ic_start = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {52'd0, o_DC_MEM_Valid, o_IC_MEM_Valid, o_DC_MEM_Data_Read, o_IC_MEM_Data_Read,
                o_DC_MEM_Last, o_IC_MEM_Last, o_SRAM_Req, o_SRAM_We, |o_SRAM_Address,
                |o_SRAM_Write_Data, |o_DC_MEM_Data, |o_IC_MEM_Data};
    endfunction

    function automatic vec_t mk(bit ic, bit rd, logic [20:0] addr, logic [20:0] eb,
                                logic [31:0] w0, logic [31:0] step, int aw, bit tm);
        vec_t v;
        v.ic = ic; v.rd = rd; v.addr = addr; v.exp_base = eb;
        for (int i = 0; i < 4; i++) v.w[i] = w0 + step * i;
        v.ack_wait = aw; v.timing = tm;
        return v;
    endfunction

    initial begin
        logic [20:0] hold_addr;
        logic        hold_we;
        logic [31:0] hold_wd;
        logic        prev_req;
        int          wcnt;
        prev_req = 1'b0; wcnt = 0;
        hold_addr = '0; hold_we = 1'b0; hold_wd = '0;
        i_SRAM_Ack = 1'b0; i_SRAM_Read_Data = '0;
        i_DC_MEM_Data = '0; i_IC_MEM_Data = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (int'(o_DC_MEM_Valid) + int'(o_DC_MEM_Data_Read) + int'(o_IC_MEM_Valid) + int'(o_IC_MEM_Data_Read) > 1)
                overlap++;
            if (o_DC_MEM_Valid || o_DC_MEM_Data_Read || o_IC_MEM_Valid || o_IC_MEM_Data_Read) begin
                logic isic;
                isic = o_IC_MEM_Valid | o_IC_MEM_Data_Read;
                b_ic.push_back(isic);
                b_kind.push_back(o_DC_MEM_Valid | o_IC_MEM_Valid);
                b_last.push_back(isic ? o_IC_MEM_Last : o_DC_MEM_Last);
                b_data.push_back(isic ? o_IC_MEM_Data : o_DC_MEM_Data);
                b_cyc.push_back(cyc);
                if (isic ? o_DC_MEM_Last : o_IC_MEM_Last) orphan++;
            end else if (o_DC_MEM_Last || o_IC_MEM_Last) begin
                orphan++;
            end
            if (o_DC_MEM_Last || o_IC_MEM_Last) last_cnt++;
            if (o_DC_MEM_Data_Read) dc_dr_cnt++;
            if (o_IC_MEM_Data_Read) ic_dr_cnt++;
            i_DC_MEM_Data = dc_words[2'(dc_dr_cnt - dc_start)];
            i_IC_MEM_Data = ic_words[2'(ic_dr_cnt - ic_start)];
            if (o_SRAM_Req) begin
                if (!prev_req) begin
                    hold_addr = o_SRAM_Address; hold_we = o_SRAM_We; hold_wd = o_SRAM_Write_Data;
                    s_addr.push_back(o_SRAM_Address); s_we.push_back(o_SRAM_We);
                    s_wd.push_back(o_SRAM_Write_Data); s_cyc.push_back(cyc);
                    wcnt = 0;
                end else begin
                    stab_n++;
                    wcnt++;
                    if (o_SRAM_Address !== hold_addr || o_SRAM_We !== hold_we || o_SRAM_Write_Data !== hold_wd)
                        stab_bad++;
                end
                i_SRAM_Ack = (wcnt == ack_wait);
            end else begin
                i_SRAM_Ack = 1'b0;
            end
            prev_req = o_SRAM_Req;
            i_SRAM_Read_Data = cur_words[o_SRAM_Address[1:0]];
        end
    end

    task automatic wait_last(input int target, input string tag);
        int n;
        n = 0;
        while (last_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (last_cnt < target) check({tag, "_timeout"}, 64'(last_cnt), 64'(target));
    endtask

    task automatic check_burst(input string tag, input int s0, input int b0, input vec_t v);
        for (int i = 0; i < 4; i++) begin
            if (s0 + i < s_addr.size())
                check($sformatf("%s_sram%0d", tag, i),
                      {10'd0, s_addr[s0+i], s_we[s0+i], v.rd ? 32'd0 : s_wd[s0+i]},
                      {10'd0, v.exp_base + 21'(i), ~v.rd, v.rd ? 32'd0 : v.w[i]});
            else
                check($sformatf("%s_sram%0d_missing", tag, i), 64'(s_addr.size()), 64'(s0 + i + 1));
            if (b0 + i < b_ic.size())
                check($sformatf("%s_beat%0d", tag, i),
                      {29'd0, b_ic[b0+i], b_kind[b0+i], b_last[b0+i], v.rd ? b_data[b0+i] : 32'd0},
                      {29'd0, v.ic, v.rd, (i == 3), v.rd ? v.w[i] : 32'd0});
            else
                check($sformatf("%s_beat%0d_missing", tag, i), 64'(b_ic.size()), 64'(b0 + i + 1));
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int s0, b0, l0, t0;
        @(negedge clk);
        s0 = s_addr.size(); b0 = b_ic.size(); l0 = last_cnt;
        cur_words = v.w; ack_wait = v.ack_wait;
        if (v.ic) begin
            ic_words = v.w; ic_start = ic_dr_cnt;
            i_IC_MEM_Read_Write_n = v.rd; i_IC_MEM_Address = v.addr; i_IC_MEM_Valid = 1'b1;
        end else begin
            dc_words = v.w; dc_start = dc_dr_cnt;
            i_DC_MEM_Read_Write_n = v.rd; i_DC_MEM_Address = v.addr; i_DC_MEM_Valid = 1'b1;
        end
        t0 = cyc;
        wait_last(l0 + 1, tag);
        i_DC_MEM_Valid = 1'b0; i_IC_MEM_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_nbeats"}, 64'(b_ic.size() - b0), 64'd4);
        check({tag, "_nsram"}, 64'(s_addr.size() - s0), 64'd4);
        check_burst(tag, s0, b0, v);
        if (v.timing && s_addr.size() > s0 && b_ic.size() >= b0 + 4) begin
            check({tag, "_first_req_lat"}, 64'(s_cyc[s0] - t0), 64'd2);
            check({tag, "_last_lat"}, 64'(b_cyc[b0+3] - t0), 64'd9);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vec_t v;
        int   s0, b0, l0, n;
        vecs[0] = mk(1'b0, 1'b1, 21'h00120, 21'h00120, 32'hA0, 32'h1, 0, 1'b1);
        vecs[1] = mk(1'b0, 1'b0, 21'h00040, 21'h00040, 32'h11, 32'h11, 0, 1'b0);
        vecs[2] = mk(1'b1, 1'b1, 21'h00500, 21'h00500, 32'hDEAD_0000, 32'h1, 3, 1'b0);
        vecs[3] = mk(1'b1, 1'b0, 21'h00203, 21'h00200, 32'h5555_0001, 32'h0101_0101, 3, 1'b0);
        vecs[4] = mk(1'b0, 1'b1, 21'h1FFFFD, 21'h1FFFFC, 32'hFFFF_FFF0, 32'h1, 1, 1'b0);

        cur_words = '0; dc_words = '0; ic_words = '0;
        i_Reset_n = 1'b0;
        i_DC_MEM_Valid = 1'b0; i_DC_MEM_Read_Write_n = 1'b0; i_DC_MEM_Address = '0;
        i_IC_MEM_Valid = 1'b0; i_IC_MEM_Read_Write_n = 1'b0; i_IC_MEM_Address = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        i_Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", out_vec(), 64'd0);

        for (int i = 0; i < 5; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Writeout at 0x40 with Valid held straight into a populate at 0x80.
        @(negedge clk);
        s0 = s_addr.size(); b0 = b_ic.size(); l0 = last_cnt;
        ack_wait = 0;
        v = mk(1'b0, 1'b0, 21'h00040, 21'h00040, 32'h11, 32'h11, 0, 1'b0);
        dc_words = v.w; dc_start = dc_dr_cnt;
        cur_words = mk(1'b0, 1'b1, 21'h00080, 21'h00080, 32'hB0, 32'h1, 0, 1'b0).w;
        i_DC_MEM_Read_Write_n = 1'b0; i_DC_MEM_Address = 21'h00040; i_DC_MEM_Valid = 1'b1;
        wait_last(l0 + 1, "wo");
        i_DC_MEM_Read_Write_n = 1'b1; i_DC_MEM_Address = 21'h00080;
        wait_last(l0 + 2, "pop");
        i_DC_MEM_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wopop_nsram", 64'(s_addr.size() - s0), 64'd8);
        check_burst("wo", s0, b0, v);
        check_burst("pop", s0 + 4, b0 + 4, mk(1'b0, 1'b1, 21'h00080, 21'h00080, 32'hB0, 32'h1, 0, 1'b0));
        if (s_addr.size() >= s0 + 5 && b_ic.size() >= b0 + 4)
            check("wopop_gap", 64'(s_cyc[s0+4] - b_cyc[b0+3]), 64'd3);

        // Asynchronous reset while beat 2 of a DC read is outstanding.
        @(negedge clk);
        s0 = s_addr.size();
        ack_wait = 2;
        cur_words = mk(1'b0, 1'b1, 21'h00120, 21'h00120, 32'hA0, 32'h1, 0, 1'b0).w;
        i_DC_MEM_Read_Write_n = 1'b1; i_DC_MEM_Address = 21'h00120; i_DC_MEM_Valid = 1'b1;
        n = 0;
        while (s_addr.size() < s0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_beat2", 64'(s_addr.size() >= s0 + 3), 64'd1);
        check("rst_req_before", 64'(o_SRAM_Req), 64'd1);
        i_Reset_n = 1'b0; i_DC_MEM_Valid = 1'b0;
        #1;
        check("rst_midburst_outputs", out_vec(), 64'd0);
        @(negedge clk);
        i_Reset_n = 1'b1;
        run_vector(mk(1'b1, 1'b1, 21'h00300, 21'h00300, 32'hC0, 32'h1, 0, 1'b1), "post_rst");

        // Both clients request together and keep requesting: DC, IC, DC.
        @(negedge clk);
        s0 = s_addr.size(); b0 = b_ic.size(); l0 = last_cnt;
        ack_wait = 0;
        cur_words = mk(1'b0, 1'b1, 21'h0, 21'h0, 32'h7000, 32'h1, 0, 1'b0).w;
        i_DC_MEM_Read_Write_n = 1'b1; i_DC_MEM_Address = 21'h00100;
        i_IC_MEM_Read_Write_n = 1'b1; i_IC_MEM_Address = 21'h00300;
        i_DC_MEM_Valid = 1'b1; i_IC_MEM_Valid = 1'b1;
        wait_last(l0 + 3, "tie");
        i_DC_MEM_Valid = 1'b0; i_IC_MEM_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("tie_nbeats", 64'(b_ic.size() - b0), 64'd12);
        check_burst("tie0", s0, b0, mk(1'b0, 1'b1, 21'h0, 21'h00100, 32'h7000, 32'h1, 0, 1'b0));
        check_burst("tie1", s0 + 4, b0 + 4, mk(1'b1, 1'b1, 21'h0, 21'h00300, 32'h7000, 32'h1, 0, 1'b0));
        check_burst("tie2", s0 + 8, b0 + 8, mk(1'b0, 1'b1, 21'h0, 21'h00100, 32'h7000, 32'h1, 0, 1'b0));

        check("sram_hold_stable", 64'(stab_bad), 64'd0);
        check("sram_hold_exercised", 64'(stab_n > 0), 64'd1);
        check("strobe_overlap", 64'(overlap), 64'd0);
        check("last_orphan", 64'(orphan), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
